mips_instruction_buffer: RTL and testbench

Parametrised instruction holding queue between the memory read port and the decode stage of the multi-cycle MIPS core. It captures fetched words and presents them in order to decode, holding them while the memory port is busy with data loads/stores. It is the generalised successor of the single-entry instruction holding register, adding configurable depth and width, valid/ready handshakes, flush on control-flow change, and an optional zero-latency bypass when empty.

---
 rtl/mips_instruction_buffer_if.sv | 45 ++++
 rtl/mips_instruction_buffer.sv | 105 ++++++++++
 tb/tb_mips_instruction_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instruction_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_instruction_buffer_if
//  Description : Handshake bundle between the memory read port, the
//                instruction buffer and the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_instruction_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                         flush;
    logic                         in_valid;
    logic [WIDTH-1:0]             in_data;
    logic                         in_ready;
    logic                         out_valid;
    logic [WIDTH-1:0]             out_data;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // Side driving memory words in and consuming them at decode
    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    // The buffer itself
    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );
endinterface
`default_nettype wire

// File: rtl/mips_instruction_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : mips_instruction_buffer
//  Description : Circular instruction holding queue between the memory read
//                port and decode, with flush and optional empty-bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_instruction_buffer #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mips_instruction_buffer_if.slave bus
);
    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam int                 c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
    localparam logic               c_BYPASS    = (BYPASS != 0);

    // Storage is deliberately left unreset; validity is tracked by r_count
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wp;
    logic [c_PTR_W-1:0] r_rp;
    logic [c_CNT_W-1:0] r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_out_data;

    // Pointer increment modulo DEPTH (DEPTH need not be a power of two)
    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH_CNT);

    // Readiness looks only at stored occupancy so out_ready never reaches in_ready
    assign w_in_ready  = ~w_full & ~bus.flush & ~reset;
    assign w_out_valid = ~reset & ~bus.flush & (~w_empty | (c_BYPASS & bus.in_valid));

    // A bypassed word goes straight to decode and is never stored
    assign w_bypass = c_BYPASS & w_empty & bus.in_valid & bus.out_ready & w_in_ready;
    assign w_push   = bus.in_valid & w_in_ready & ~w_bypass;
    assign w_pop    = w_out_valid & bus.out_ready & ~w_empty;

    // Head selection: stored head, else bypassed input, else zero
    always_comb begin
        w_out_data = '0;
        if (w_out_valid) begin
            if (!w_empty) begin
                w_out_data = r_mem[r_rp];
            end else begin
                w_out_data = bus.in_data;
            end
        end
    end

    // Write accepted words into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= bus.in_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush outranks push and pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= ptr_next(r_wp);
            end
            if (w_pop) begin
                r_rp <= ptr_next(r_rp);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_instruction_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_instruction_buffer
//  Description : Self-checking bench for mips_instruction_buffer, one instance
//                with bypass and one without, sharing clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_instruction_buffer;
    localparam int c_WIDTH = 32;
    localparam int c_DEPTH = 4;

    logic clk;
    logic reset;

    mips_instruction_buffer_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) ia ();
    mips_instruction_buffer_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) ib ();

    mips_instruction_buffer #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .BYPASS(1)) u_dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
    );

    mips_instruction_buffer #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .BYPASS(0)) u_dut_reg (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        r;
        logic        ov;
        logic [31:0] od;
        logic        ir;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tv [34];

    // Reference model state: a plain queue of stored words per instance
    logic [31:0] mq0 [$];
    logic [31:0] mq1 [$];

    logic        s_fl;
    logic        s_iv;
    logic [31:0] s_d;
    logic        s_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic fl, input logic iv,
                         input logic [31:0] d, input logic r);
        if (sel) begin
            ib.flush = fl; ib.in_valid = iv; ib.in_data = d; ib.out_ready = r;
        end else begin
            ia.flush = fl; ia.in_valid = iv; ia.in_data = d; ia.out_ready = r;
        end
    endtask

    task automatic chk_outs(input bit sel, input string tag, input logic ov,
                            input logic [31:0] od, input logic ir, input logic [2:0] cnt);
        if (sel) begin
            chk({tag, ".out_valid"}, {31'b0, ib.out_valid}, {31'b0, ov});
            chk({tag, ".out_data"},  ib.out_data, od);
            chk({tag, ".in_ready"},  {31'b0, ib.in_ready}, {31'b0, ir});
            chk({tag, ".count"},     {29'b0, ib.count}, {29'b0, cnt});
        end else begin
            chk({tag, ".out_valid"}, {31'b0, ia.out_valid}, {31'b0, ov});
            chk({tag, ".out_data"},  ia.out_data, od);
            chk({tag, ".in_ready"},  {31'b0, ia.in_ready}, {31'b0, ir});
            chk({tag, ".count"},     {29'b0, ia.count}, {29'b0, cnt});
        end
    endtask

    // Queue-level model: derive expected outputs from stored words and the
    // current inputs, compare, then apply the accepted transfers.
    task automatic model_step(input bit sel, input int cyc);
        logic [31:0] q [$];
        logic        byp;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        q    = sel ? mq1 : mq0;
        byp  = ~sel;
        e_ir = (q.size() < c_DEPTH) && !s_fl;
        e_ov = !s_fl && (q.size() > 0 || (byp && s_iv));
        e_od = !e_ov ? 32'h0 : (q.size() > 0 ? q[0] : s_d);
        chk_outs(sel, $sformatf("rnd%0d[%0d]", sel, cyc), e_ov, e_od, e_ir, 3'(q.size()));
        if (s_fl) begin
            q.delete();
        end else if (!(q.size() == 0 && byp && s_iv && s_r)) begin
            if (e_ov && s_r) void'(q.pop_front());
            if (s_iv && e_ir) q.push_back(s_d);
        end
        if (sel) mq1 = q; else mq0 = q;
    endtask

    initial begin
        //            fl iv  data          r  ov  od            ir cnt
        tv[0]  = '{1'b0,1'b0,32'h0       ,1'b0,1'b0,32'h0       ,1'b1,3'd0};
        tv[1]  = '{1'b0,1'b1,32'h8C220004,1'b1,1'b1,32'h8C220004,1'b1,3'd0};
        tv[2]  = '{1'b0,1'b0,32'h0       ,1'b0,1'b0,32'h0       ,1'b1,3'd0};
        tv[3]  = '{1'b0,1'b1,32'h1       ,1'b0,1'b1,32'h1       ,1'b1,3'd0};
        tv[4]  = '{1'b0,1'b1,32'h2       ,1'b0,1'b1,32'h1       ,1'b1,3'd1};
        tv[5]  = '{1'b0,1'b1,32'h3       ,1'b0,1'b1,32'h1       ,1'b1,3'd2};
        tv[6]  = '{1'b0,1'b1,32'h4       ,1'b0,1'b1,32'h1       ,1'b1,3'd3};
        tv[7]  = '{1'b0,1'b1,32'h5       ,1'b0,1'b1,32'h1       ,1'b0,3'd4};
        tv[8]  = '{1'b0,1'b0,32'h0       ,1'b1,1'b1,32'h1       ,1'b0,3'd4};
        tv[9]  = '{1'b0,1'b0,32'h0       ,1'b1,1'b1,32'h2       ,1'b1,3'd3};
        tv[10] = '{1'b0,1'b1,32'h5       ,1'b0,1'b1,32'h3       ,1'b1,3'd2};
        tv[11] = '{1'b0,1'b1,32'h6       ,1'b0,1'b1,32'h3       ,1'b1,3'd3};
        tv[12] = '{1'b0,1'b0,32'h0       ,1'b1,1'b1,32'h3       ,1'b0,3'd4};
        tv[13] = '{1'b0,1'b0,32'h0       ,1'b1,1'b1,32'h4       ,1'b1,3'd3};
        tv[14] = '{1'b0,1'b0,32'h0       ,1'b1,1'b1,32'h5       ,1'b1,3'd2};
        tv[15] = '{1'b0,1'b0,32'h0       ,1'b1,1'b1,32'h6       ,1'b1,3'd1};
        tv[16] = '{1'b0,1'b0,32'h0       ,1'b0,1'b0,32'h0       ,1'b1,3'd0};
        tv[17] = '{1'b0,1'b1,32'h10      ,1'b0,1'b1,32'h10      ,1'b1,3'd0};
        tv[18] = '{1'b0,1'b1,32'h11      ,1'b0,1'b1,32'h10      ,1'b1,3'd1};
        tv[19] = '{1'b0,1'b1,32'h12      ,1'b1,1'b1,32'h10      ,1'b1,3'd2};
        tv[20] = '{1'b0,1'b1,32'h13      ,1'b1,1'b1,32'h11      ,1'b1,3'd2};
        tv[21] = '{1'b0,1'b1,32'h14      ,1'b1,1'b1,32'h12      ,1'b1,3'd2};
        tv[22] = '{1'b0,1'b0,32'h0       ,1'b1,1'b1,32'h13      ,1'b1,3'd2};
        tv[23] = '{1'b0,1'b0,32'h0       ,1'b1,1'b1,32'h14      ,1'b1,3'd1};
        tv[24] = '{1'b0,1'b1,32'h20      ,1'b0,1'b1,32'h20      ,1'b1,3'd0};
        tv[25] = '{1'b0,1'b1,32'h21      ,1'b0,1'b1,32'h20      ,1'b1,3'd1};
        tv[26] = '{1'b0,1'b1,32'h22      ,1'b0,1'b1,32'h20      ,1'b1,3'd2};
        tv[27] = '{1'b1,1'b1,32'h99      ,1'b1,1'b0,32'h0       ,1'b0,3'd3};
        tv[28] = '{1'b0,1'b0,32'h0       ,1'b0,1'b0,32'h0       ,1'b1,3'd0};
        tv[29] = '{1'b0,1'b1,32'hAC430008,1'b0,1'b1,32'hAC430008,1'b1,3'd0};
        tv[30] = '{1'b0,1'b0,32'hDEADBEEF,1'b0,1'b1,32'hAC430008,1'b1,3'd1};
        tv[31] = '{1'b0,1'b0,32'hDEADBEEF,1'b0,1'b1,32'hAC430008,1'b1,3'd1};
        tv[32] = '{1'b0,1'b0,32'hDEADBEEF,1'b1,1'b1,32'hAC430008,1'b1,3'd1};
        tv[33] = '{1'b0,1'b0,32'h0       ,1'b0,1'b0,32'h0       ,1'b1,3'd0};

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_outs(0, "reset_a", 1'b0, 32'h0, 1'b0, 3'd0);
        chk_outs(1, "reset_b", 1'b0, 32'h0, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed table on the bypass instance
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            drive(0, tv[i].fl, tv[i].iv, tv[i].d, tv[i].r);
            #1;
            chk_outs(0, $sformatf("vec%0d", i), tv[i].ov, tv[i].od, tv[i].ir, tv[i].cnt);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Registered-only instance: word appears one cycle later with count=1
        drive(1, 1'b0, 1'b1, 32'h8C220004, 1'b1);
        #1;
        chk_outs(1, "nobyp_c0", 1'b0, 32'h0, 1'b1, 3'd0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk_outs(1, "nobyp_c1", 1'b1, 32'h8C220004, 1'b1, 3'd1);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_outs(1, "nobyp_c2", 1'b0, 32'h0, 1'b1, 3'd0);

        // Random traffic against the queue model on both instances
        mq0.delete();
        mq1.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            s_fl = ($urandom_range(0, 15) == 0);
            s_iv = ($urandom_range(0, 2) != 0);
            s_d  = $urandom;
            s_r  = ($urandom_range(0, 2) != 0);
            drive(0, s_fl, s_iv, s_d, s_r);
            drive(1, s_fl, s_iv, s_d, s_r);
            #1;
            model_step(0, c);
            model_step(1, c);
        end

        // Reset asserted mid-cycle with words held
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h77, 1'b0);
        drive(1, 1'b0, 1'b1, 32'h78, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_outs(0, "midreset_a", 1'b0, 32'h0, 1'b0, 3'd0);
        chk_outs(1, "midreset_b", 1'b0, 32'h0, 1'b0, 3'd0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk_outs(0, "postreset_a", 1'b0, 32'h0, 1'b1, 3'd0);
        chk_outs(1, "postreset_b", 1'b0, 32'h0, 1'b1, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
